// File: rtl/instmem_loader.sv
// Instruction-memory loader: decodes per-PE segment headers, streams packed words into PE memories, then enables execution.
// Optional build macro INSTMEM_LOADER_BROADCAST_EN: header bit 62 writes the segment to every PE.
module instmem_loader #(
  parameter int N_PE     = 16,
  parameter int PE_SEL_W = 4,
  parameter int AWIDTH   = 6,
  parameter int DWIDTH   = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic [DWIDTH-1:0] In_Data,
  output logic              In_Ready,
  input  logic              Stop,
  output logic [N_PE-1:0]   Write_En,
  output logic [AWIDTH-1:0] Write_Addr,
  output logic [DWIDTH-1:0] In_Inst,
  output logic              exec_en,
  output logic              Load_Done,
  output logic              Err
);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state_r;
  logic                in_ready_r;
  logic [N_PE-1:0]     write_en_r;
  logic [AWIDTH-1:0]   write_addr_r;
  logic [DWIDTH-1:0]   in_inst_r;
  logic                exec_en_r;
  logic                load_done_r;
  logic                err_r;
  logic [N_PE-1:0]     mask_r;
  logic                last_r;
  logic [4:0]          words_r;
  logic [AWIDTH-1:0]   addr_r;

  logic                accept_s;
  logic [5:0]          hdr_count_s;
  logic [31:0]         hdr_id_s;
  logic                hdr_bcast_s;
  logic                hdr_bad_s;
  logic [4:0]          hdr_words_s;
  logic [N_PE-1:0]     hdr_mask_s;

  assign accept_s = In_Valid && in_ready_r;

  // Header field decode and segment write-mask generation
  always_comb begin
    hdr_count_s = In_Data[5:0];
    hdr_id_s    = 32'(In_Data[6+PE_SEL_W-1:6]);
`ifdef INSTMEM_LOADER_BROADCAST_EN
    hdr_bcast_s = In_Data[DWIDTH-2];
`else
    hdr_bcast_s = 1'b0;
`endif
    // Three instructions per packed word: words = ceil(count / 3)
    hdr_words_s = 5'((7'(hdr_count_s) + 7'd2) / 7'd3);
    hdr_bad_s   = (hdr_count_s == 6'd0) ||
                  (!hdr_bcast_s && (hdr_id_s >= 32'(N_PE)));
    hdr_mask_s  = '0;
    for (int i = 0; i < N_PE; i++) begin
      hdr_mask_s[i] = hdr_bcast_s || (hdr_id_s == 32'(i));
    end
  end

  // Loader FSM with registered memory-side and control outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= HDR;
      in_ready_r   <= 1'b0;
      write_en_r   <= '0;
      write_addr_r <= '0;
      in_inst_r    <= '0;
      exec_en_r    <= 1'b0;
      load_done_r  <= 1'b0;
      err_r        <= 1'b0;
      mask_r       <= '0;
      last_r       <= 1'b0;
      words_r      <= 5'd0;
      addr_r       <= '0;
    end else begin
      write_en_r  <= '0;
      load_done_r <= 1'b0;
      case (state_r)
        HDR: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            if (hdr_bad_s) begin
              err_r <= 1'b1;
            end else begin
              mask_r  <= hdr_mask_s;
              last_r  <= In_Data[DWIDTH-1];
              words_r <= hdr_words_s;
              addr_r  <= '0;
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            write_en_r   <= mask_r;
            write_addr_r <= addr_r;
            in_inst_r    <= In_Data;
            addr_r       <= addr_r + AWIDTH'(3);
            words_r      <= words_r - 5'd1;
            if (words_r == 5'd1) begin
              load_done_r <= 1'b1;
              if (last_r) begin
                state_r    <= RUN;
                in_ready_r <= 1'b0;
              end else begin
                state_r <= HDR;
              end
            end
          end
        end
        RUN: begin
          // exec_en rises one cycle after the final write; Stop acts once it is high
          if (exec_en_r && Stop) begin
            exec_en_r  <= 1'b0;
            in_ready_r <= 1'b1;
            state_r    <= HDR;
          end else begin
            exec_en_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= HDR;
          in_ready_r <= 1'b1;
          exec_en_r  <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready   = in_ready_r;
  assign Write_En   = write_en_r;
  assign Write_Addr = write_addr_r;
  assign In_Inst    = in_inst_r;
  assign exec_en    = exec_en_r;
  assign Load_Done  = load_done_r;
  assign Err        = err_r;

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: segment table plus hand-written sequences, writes checked by a scoreboard.
module tb_instmem_loader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        In_Valid;
  logic [63:0] In_Data;
  logic        In_Ready;
  logic        Stop;
  logic [15:0] Write_En;
  logic [5:0]  Write_Addr;
  logic [63:0] In_Inst;
  logic        exec_en;
  logic        Load_Done;
  logic        Err;

  logic        s_valid;
  logic [63:0] s_data;
  logic        s_ready;
  logic        s_stop;
  logic [11:0] s_we;
  logic [5:0]  s_addr;
  logic [63:0] s_inst;
  logic        s_exec;
  logic        s_done;
  logic        s_err;

  instmem_loader dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
    .Stop(Stop), .Write_En(Write_En), .Write_Addr(Write_Addr), .In_Inst(In_Inst),
    .exec_en(exec_en), .Load_Done(Load_Done), .Err(Err)
  );

  // Second instance with fewer PEs so an out-of-range PE id is representable
  instmem_loader #(.N_PE(12), .PE_SEL_W(4), .AWIDTH(6), .DWIDTH(64)) dut12 (
    .Clk(Clk), .Reset(Reset), .In_Valid(s_valid), .In_Data(s_data), .In_Ready(s_ready),
    .Stop(s_stop), .Write_En(s_we), .Write_Addr(s_addr), .In_Inst(s_inst),
    .exec_en(s_exec), .Load_Done(s_done), .Err(s_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] we;
    logic [5:0]  addr;
    logic [63:0] inst;
    logic        done;
  } wr_t;

  typedef struct {
    int c;
    int id;
    bit bc;
    bit b2b;
    int gap;
    bit exp_err;
  } seg_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input int c, input int id, input bit bc, input bit last);
    logic [63:0] h;
    h       = 64'd0;
    h[5:0]  = c[5:0];
    h[9:6]  = id[3:0];
    h[62]   = bc;
    h[63]   = last;
    return h;
  endfunction

  function automatic logic [15:0] exp_mask(input int id, input bit bc);
`ifdef INSTMEM_LOADER_BROADCAST_EN
    if (bc) return 16'hFFFF;
`endif
    return 16'd1 << id;
  endfunction

  task automatic step(input logic v, input logic [63:0] d);
    In_Valid = v;
    In_Data  = d;
    @(negedge Clk);
  endtask

  task automatic load_seg(input int c, input int id, input bit bc, input bit last,
                          input int gap, input bit idle);
    int          w;
    logic [63:0] d;
    wr_t         e;
    step(1'b1, mk_hdr(c, id, bc, last));
    w = (c + 2) / 3;
    for (int i = 0; i < w; i++) begin
      repeat (gap) step(1'b0, 64'hDEAD_BEEF_0000_0000);
      d      = {$urandom, $urandom};
      e.we   = exp_mask(id, bc);
      e.addr = 6'(3 * i);
      e.inst = d;
      e.done = (i == w - 1);
      sb.push_back(e);
      step(1'b1, d);
    end
    if (idle) step(1'b0, 64'd0);
  endtask

  // Scoreboard: every observed write must match the oldest expected one
  always @(negedge Clk) begin : mon
    wr_t exp_w;
    if (Reset) begin
      if (Write_En != 16'd0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_write got we=%h addr=%0d expected no write", Write_En, Write_Addr);
        end else begin
          exp_w = sb.pop_front();
          if ({Write_En, Write_Addr, In_Inst, Load_Done} !== exp_w) begin
            errors++;
            $display("FAIL write got we=%h addr=%0d inst=%h done=%b expected we=%h addr=%0d inst=%h done=%b",
                     Write_En, Write_Addr, In_Inst, Load_Done, exp_w.we, exp_w.addr, exp_w.inst, exp_w.done);
          end
        end
        if (exec_en) begin
          errors++;
          $display("FAIL write_during_exec got exec_en=1 expected 0");
        end
      end else if (Load_Done) begin
        checks++;
        errors++;
        $display("FAIL lone_load_done got 1 expected 0");
      end
    end
  end

  seg_t segs[6];
  int   hi;

  initial begin
    segs[0] = '{c: 63, id: 15, bc: 1'b0, b2b: 1'b0, gap: 0, exp_err: 1'b0};
    segs[1] = '{c: 9,  id: 7,  bc: 1'b0, b2b: 1'b0, gap: 3, exp_err: 1'b0};
    segs[2] = '{c: 3,  id: 3,  bc: 1'b1, b2b: 1'b1, gap: 0, exp_err: 1'b0};
    segs[3] = '{c: 4,  id: 0,  bc: 1'b0, b2b: 1'b0, gap: 1, exp_err: 1'b0};
    segs[4] = '{c: 0,  id: 2,  bc: 1'b0, b2b: 1'b0, gap: 0, exp_err: 1'b1};
    segs[5] = '{c: 5,  id: 9,  bc: 1'b0, b2b: 1'b0, gap: 0, exp_err: 1'b1};

    Reset = 1'b0; In_Valid = 1'b0; In_Data = 64'd0; Stop = 1'b0;
    s_valid = 1'b0; s_data = 64'd0; s_stop = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_in_ready", 64'(In_Ready), 64'd0);
    check("rst_write_en", 64'(Write_En), 64'd0);
    check("rst_write_addr", 64'(Write_Addr), 64'd0);
    check("rst_in_inst", In_Inst, 64'd0);
    check("rst_exec_en", 64'(exec_en), 64'd0);
    check("rst_load_done", 64'(Load_Done), 64'd0);
    check("rst_err", 64'(Err), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("ready_after_rst", 64'(In_Ready), 64'd1);

    // Last segment C=6 to PE 2, then RUN and Stop
    load_seg(6, 2, 1'b0, 1'b1, 0, 1'b0);
    check("run_in_ready", 64'(In_Ready), 64'd0);
    check("exec_not_yet", 64'(exec_en), 64'd0);
    step(1'b0, 64'd0);
    check("exec_rises", 64'(exec_en), 64'd1);
    step(1'b1, mk_hdr(3, 1, 1'b0, 1'b0));
    check("run_ignores_data", 64'(In_Ready), 64'd0);
    check("exec_held", 64'(exec_en), 64'd1);
    In_Valid = 1'b0;
    Stop = 1'b1;
    step(1'b0, 64'd0);
    Stop = 1'b0;
    check("stop_exec_en", 64'(exec_en), 64'd0);
    check("stop_in_ready", 64'(In_Ready), 64'd1);
    check("sb_empty_run", 64'(sb.size()), 64'd0);

    foreach (segs[i]) begin
      load_seg(segs[i].c, segs[i].id, segs[i].bc, 1'b0, segs[i].gap, !segs[i].b2b);
      if (!segs[i].b2b) begin
        check("seg_sb_empty", 64'(sb.size()), 64'd0);
        check("seg_err", 64'(Err), 64'(segs[i].exp_err));
        check("seg_exec_en", 64'(exec_en), 64'd0);
        check("seg_in_ready", 64'(In_Ready), 64'd1);
      end
    end

    // Stop raised in the first exec_en cycle: exec_en high exactly once
    load_seg(3, 5, 1'b0, 1'b1, 0, 1'b1);
    hi = int'(exec_en);
    Stop = 1'b1;
    step(1'b0, 64'd0);
    Stop = 1'b0;
    repeat (4) begin
      hi += int'(exec_en);
      step(1'b0, 64'd0);
    end
    check("exec_one_cycle", 64'(hi), 64'd1);
    Stop = 1'b1;
    step(1'b0, 64'd0);
    Stop = 1'b0;
    check("stop_in_hdr_ignored", 64'({In_Ready, exec_en}), 64'b10);

    // Reset in the middle of a C=9 segment
    begin
      logic [63:0] d;
      wr_t         e;
      step(1'b1, mk_hdr(9, 1, 1'b0, 1'b0));
      d = {$urandom, $urandom};
      e = '{we: 16'h0002, addr: 6'd0, inst: d, done: 1'b0};
      sb.push_back(e);
      step(1'b1, d);
      In_Valid = 1'b0;
      #1 Reset = 1'b0;
      #1;
      check("midrst_outputs", 64'({In_Ready, Write_En, Write_Addr, exec_en, Load_Done, Err}), 64'd0);
      check("midrst_inst", In_Inst, 64'd0);
      check("midrst_sb_empty", 64'(sb.size()), 64'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      load_seg(3, 1, 1'b0, 1'b0, 0, 1'b1);
      check("postrst_sb_empty", 64'(sb.size()), 64'd0);
      check("postrst_err", 64'(Err), 64'd0);
    end

    // Out-of-range PE id on the 12-PE instance
    s_valid = 1'b1;
    s_data  = mk_hdr(3, 13, 1'b0, 1'b0);
    @(negedge Clk);
    check("id_range_err", 64'(s_err), 64'd1);
    check("id_range_no_write", 64'(s_we), 64'd0);
    s_data = mk_hdr(3, 11, 1'b0, 1'b0);
    @(negedge Clk);
    s_data = 64'h0123_4567_89AB_CDEF;
    @(negedge Clk);
    s_valid = 1'b0;
    check("id_after_err_we", 64'(s_we), 64'h800);
    check("id_after_err_addr_done", 64'({s_addr, s_done}), 64'b0000001);
    check("id_after_err_inst", s_inst, 64'h0123_4567_89AB_CDEF);
    check("id_err_sticky", 64'(s_err), 64'd1);

    step(1'b0, 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
